// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory, with locked sequences.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration (default is fixed priority, port 0 first).
//
// state | meaning
// IDLE  | arbitrate between both ports
// LOCK0 | bus held by port 0, port 1 waits
// LOCK1 | bus held by port 1, port 0 waits
module mem_arbiter #(
    parameter int AWIDTH   = 16,
    parameter int DWIDTH   = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [AWIDTH-2:0] p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DWIDTH-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [AWIDTH-2:0] p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DWIDTH-1:0] p1_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [AWIDTH-2:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   lock_cnt, lock_cnt_nxt;
    logic            yield, yield_nxt;
    logic            last, last_nxt;     // last granted port (1 = port 1)
    logic            contend_p1;
    logic            any_gnt, w_we, w_lock;

`ifdef MEM_ARB_RR_EN
    assign contend_p1 = ~last;
`else
    assign contend_p1 = yield & ~last;
`endif

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        case (state)
            LOCK0:   p0_gnt = p0_req;
            LOCK1:   p1_gnt = p1_req;
            default: begin
                if (p0_req && p1_req) begin
                    p1_gnt = contend_p1;
                    p0_gnt = ~contend_p1;
                end else begin
                    p0_gnt = p0_req;
                    p1_gnt = p1_req;
                end
            end
        endcase
        if (rst) begin
            p0_gnt = 1'b0;
            p1_gnt = 1'b0;
        end
    end

    assign any_gnt   = p0_gnt | p1_gnt;
    assign w_we      = p1_gnt ? p1_we   : p0_we;
    assign w_lock    = p1_gnt ? p1_lock : p0_lock;
    assign mem_re    = any_gnt & ~w_we;
    assign mem_we    = any_gnt & w_we;
    assign mem_addr  = !any_gnt ? '0 : (p1_gnt ? p1_addr  : p0_addr);
    assign mem_wdata = !any_gnt ? '0 : (p1_gnt ? p1_wdata : p0_wdata);
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        yield_nxt    = yield;
        last_nxt     = last;
        if (any_gnt) begin
            last_nxt  = p1_gnt;
            yield_nxt = 1'b0;
            if (state == IDLE) begin
                if (w_lock) begin
                    if (MAX_LOCK <= 1) begin
                        yield_nxt    = 1'b1;
                        lock_cnt_nxt = '0;
                    end else begin
                        state_nxt    = p1_gnt ? LOCK1 : LOCK0;
                        lock_cnt_nxt = CW'(1);
                    end
                end
            end else if (!w_lock) begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end else if (lock_cnt == CW'(MAX_LOCK - 1)) begin
                // hold limit reached: force release and let the other port in next
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
                yield_nxt    = 1'b1;
            end else begin
                lock_cnt_nxt = lock_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            yield     <= 1'b0;
            last      <= 1'b1;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_cnt  <= lock_cnt_nxt;
            yield     <= yield_nxt;
            last      <= last_nxt;
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected grants/read data,
// a negedge monitor pops and compares whenever the DUT shows a grant or rvalid.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    logic p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
    logic [AW-2:0] p0_addr, p1_addr, mem_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, mem_wdata, p0_rdata, p1_rdata;
    logic [DW-1:0] mem_rdata = '0;
    logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_re, mem_we;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_LOCK(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(int a);
        if (a == 5) return 16'h1234;
        return 16'hA5A5 ^ 16'(a);
    endfunction

    // memory model: registered read, write on posedge, unwritten words read pat()
    logic [DW-1:0] mem [256];
    bit   [255:0]  wr_flag;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:0]]     <= mem_wdata;
            wr_flag[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_re)
            mem_rdata <= wr_flag[mem_addr[7:0]] ? mem[mem_addr[7:0]] : pat(int'(mem_addr[7:0]));
    end

    typedef struct { int cyc; bit port; bit we; logic [AW-2:0] addr; logic [DW-1:0] wd; } g_t;
    typedef struct { int cyc; bit port; logic [DW-1:0] d; } r_t;
    g_t gq[$];
    r_t rq[$];

    int nvec = 0;
    int nfail = 0;

    task automatic chk(string name, logic [79:0] got, logic [79:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic push_g(int c, bit port, bit we, int a, int wd);
        g_t e;
        e.cyc = c; e.port = port; e.we = we; e.addr = 15'(a); e.wd = 16'(wd);
        gq.push_back(e);
    endtask

    task automatic push_r(int c, bit port, logic [DW-1:0] d);
        r_t e;
        e.cyc = c; e.port = port; e.d = d;
        rq.push_back(e);
    endtask

    always @(negedge clk) begin
        g_t g;
        r_t r;
        chk("one_gnt", {79'd0, p0_gnt & p1_gnt}, 80'd0);
        if (p0_gnt || p1_gnt) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", {79'd0, p1_gnt}, 80'hDEAD);
            end else begin
                g = gq.pop_front();
                chk("gnt", {14'd0, 32'(cyc), p1_gnt, mem_we, mem_re, mem_addr, mem_wdata},
                    {14'd0, 32'(g.cyc), g.port, g.we, ~g.we, g.addr, g.wd});
            end
        end else begin
            chk("idle_bus", {46'd0, mem_re, mem_we, mem_addr, mem_wdata}, 80'd0);
        end
        if (p0_rvalid || p1_rvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", {78'd0, p1_rvalid, p0_rvalid}, 80'hDEAD);
            end else begin
                r = rq.pop_front();
                chk("rdata", {30'd0, 32'(cyc), p1_rvalid, p0_rvalid, p1_rvalid ? p1_rdata : p0_rdata},
                    {30'd0, 32'(r.cyc), r.port, ~r.port, r.d});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(bit rq_, bit we, bit lk, int a, int d);
        p0_req = rq_; p0_we = we; p0_lock = lk; p0_addr = 15'(a); p0_wdata = 16'(d);
    endtask

    task automatic drv1(bit rq_, bit we, bit lk, int a, int d);
        p1_req = rq_; p1_we = we; p1_lock = lk; p1_addr = 15'(a); p1_wdata = 16'(d);
    endtask

    initial begin
        rst = 1'b1;
        drv0(1, 0, 0, 1, 0);
        drv1(1, 0, 0, 2, 0);
        step();
        @(negedge clk);
        chk("rst_gnt", {76'd0, p0_gnt, p1_gnt, mem_re, mem_we}, 80'd0);
        chk("rst_rvalid", {78'd0, p0_rvalid, p1_rvalid}, 80'd0);
        step();
        rst = 1'b0;
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        step();

        // single p0 read of rom[5]
        drv0(1, 0, 0, 5, 0);
        push_g(cyc, 0, 0, 5, 0); push_r(cyc + 1, 0, 16'h1234);
        step();
        drv0(0, 0, 0, 0, 0);
        step();

        // p1 alone, so the round-robin pointer points at port 1
        drv1(1, 0, 0, 3, 0);
        push_g(cyc, 1, 0, 3, 0); push_r(cyc + 1, 1, pat(3));
        step();
        drv1(0, 0, 0, 0, 0);
        step();

        // both ports reading continuously
`ifdef MEM_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            drv0(1, 0, 0, 1, 0);
            drv1(1, 0, 0, 2, 0);
            if (i % 2 == 0) begin
                push_g(cyc, 0, 0, 1, 0); push_r(cyc + 1, 0, pat(1));
            end else begin
                push_g(cyc, 1, 0, 2, 0); push_r(cyc + 1, 1, pat(2));
            end
            step();
        end
`else
        for (int i = 0; i < 5; i++) begin
            drv0(i < 4, 0, 0, 1, 0);
            drv1(1, 0, 0, 2, 0);
            if (i < 4) begin
                push_g(cyc, 0, 0, 1, 0); push_r(cyc + 1, 0, pat(1));
            end else begin
                push_g(cyc, 1, 0, 2, 0); push_r(cyc + 1, 1, pat(2));
            end
            step();
        end
`endif
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        step();

        // p0 locked for 3 accesses, unlocked 4th, p1 waiting throughout
        for (int i = 0; i < 4; i++) begin
            drv0(1, 0, i < 3, 'h20 + i, 0);
            drv1(1, 0, 0, 'h30, 0);
            push_g(cyc, 0, 0, 'h20 + i, 0); push_r(cyc + 1, 0, pat('h20 + i));
            step();
        end
        drv0(0, 0, 0, 0, 0);
        push_g(cyc, 1, 0, 'h30, 0); push_r(cyc + 1, 1, pat('h30));
        step();
        drv1(0, 0, 0, 0, 0);
        step();

        // p1 holds the bus while idle; p0 waits
        drv1(1, 0, 1, 'h40, 0);
        push_g(cyc, 1, 0, 'h40, 0); push_r(cyc + 1, 1, pat('h40));
        step();
        drv1(0, 0, 0, 0, 0);
        drv0(1, 0, 0, 'h41, 0);
        step();
        drv1(1, 0, 0, 'h42, 0);
        push_g(cyc, 1, 0, 'h42, 0); push_r(cyc + 1, 1, pat('h42));
        step();
        drv1(0, 0, 0, 0, 0);
        push_g(cyc, 0, 0, 'h41, 0); push_r(cyc + 1, 0, pat('h41));
        step();
        drv0(0, 0, 0, 0, 0);
        step();

        // forced release after 8 locked grants, then yield to p1
        for (int i = 0; i < 8; i++) begin
            drv0(1, 0, 1, 'h50 + i, 0);
            drv1(i >= 1, 0, 0, 'h60, 0);
            push_g(cyc, 0, 0, 'h50 + i, 0); push_r(cyc + 1, 0, pat('h50 + i));
            step();
        end
        drv0(1, 0, 1, 'h58, 0);
        push_g(cyc, 1, 0, 'h60, 0); push_r(cyc + 1, 1, pat('h60));
        step();
        drv1(0, 0, 0, 0, 0);
        drv0(1, 0, 0, 'h58, 0);
        push_g(cyc, 0, 0, 'h58, 0); push_r(cyc + 1, 0, pat('h58));
        step();
        drv0(0, 0, 0, 0, 0);
        step();

        // p1 write, p0 reads it back; writes give no rvalid
        drv1(1, 1, 0, 'h10, 'hBEEF);
        push_g(cyc, 1, 1, 'h10, 'hBEEF);
        step();
        drv1(0, 0, 0, 0, 0);
        drv0(1, 0, 0, 'h10, 0);
        push_g(cyc, 0, 0, 'h10, 0); push_r(cyc + 1, 0, 16'hBEEF);
        step();
        drv0(0, 0, 0, 0, 0);
        step();

        // reset while LOCK1 with a p1 read granted
        drv1(1, 0, 1, 'h70, 0);
        push_g(cyc, 1, 0, 'h70, 0); push_r(cyc + 1, 1, pat('h70));
        step();
        drv1(1, 0, 1, 'h71, 0);
        push_g(cyc, 1, 0, 'h71, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_lock1", {76'd0, mem_re, p1_gnt, p1_rvalid, p0_rvalid}, 80'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drv0(1, 0, 0, 'h72, 0);
        drv1(1, 0, 0, 'h73, 0);
        push_g(cyc, 0, 0, 'h72, 0); push_r(cyc + 1, 0, pat('h72));
        step();
        drv0(0, 0, 0, 0, 0);
        push_g(cyc, 1, 0, 'h73, 0); push_r(cyc + 1, 1, pat('h73));
        step();
        drv1(0, 0, 0, 0, 0);
        step();
        step();
        @(negedge clk);
        #1;
        chk("gnt_queue_empty", 80'(gq.size()), 80'd0);
        chk("rd_queue_empty", 80'(rq.size()), 80'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
